// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bip_pkg
//  Purpose  : Shared constants and types for the BIP processor and its
//             program loader (word geometry, HALT opcode, loader states).
//  Revision : 1.0 - initial release
// ============================================================================
package bip_pkg;

  // Default word geometry; one instruction is exactly two received bytes.
  localparam int C_NB_INSTRUCTION = 16;
  localparam int C_NB_ADDR        = 11;
  localparam int C_NB_OPCODE      = 5;
  localparam int C_NB_BYTE        = 8;

  // HALT opcode; the CPU decodes the same value to raise o_program_done.
  localparam logic [C_NB_OPCODE-1:0] C_HALT_OPCODE = 5'b00000;

  // Program loader state encoding.
  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_LOAD_LOW  = 3'd1,
    LD_LOAD_HIGH = 3'd2,
    LD_DONE      = 3'd3,
    LD_ERROR     = 3'd4
  } loader_state_e;

endpackage : bip_pkg
`default_nettype wire

// File: rtl/bip_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bip_program_loader
//  Purpose  : Assembles received bytes (low byte first) into instruction
//             words, writes them to program memory from address 0 upward,
//             holds the CPU in reset while loading and releases it in the
//             same cycle the HALT word is written.
//  Revision : 1.0 - initial release
// ============================================================================
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = C_NB_INSTRUCTION,
  parameter int NB_ADDR        = C_NB_ADDR,
  parameter int NB_OPCODE      = C_NB_OPCODE,
  parameter int NB_BYTE        = C_NB_BYTE
) (
  input  logic                      i_clock,
  input  logic                      i_reset,          // async, active low
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_start,
  output logic                      o_mem_wr_enable,
  output logic [NB_ADDR-1:0]        o_mem_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_mem_wr_data,
  output logic                      o_cpu_reset,
  output logic                      o_load_done,
  output logic                      o_overflow,
  output logic [NB_ADDR:0]          o_word_count
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  loader_state_e             state_q,     state_d;
  logic [NB_ADDR-1:0]        addr_q,      addr_d;
  logic [NB_ADDR:0]          count_q,     count_d;
  logic [NB_BYTE-1:0]        low_q,       low_d;
  logic                      wr_en_q,     wr_en_d;
  logic [NB_ADDR-1:0]        wr_addr_q,   wr_addr_d;
  logic [NB_INSTRUCTION-1:0] wr_data_q,   wr_data_d;
  logic                      cpu_reset_q, cpu_reset_d;
  logic                      done_q,      done_d;
  logic                      overflow_q,  overflow_d;

  // --------------------------------------------------------------------------
  // Word decode helpers
  // --------------------------------------------------------------------------
  logic [NB_INSTRUCTION-1:0] rx_word;
  logic [NB_OPCODE-1:0]      rx_opcode;
  logic                      rx_is_halt;
  logic                      addr_at_max;

  // The word being completed by the current high byte, and its opcode field.
  assign rx_word     = {i_rx_data, low_q};
  assign rx_opcode   = rx_word[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign rx_is_halt  = (rx_opcode == NB_OPCODE'(C_HALT_OPCODE));
  // Last memory location: the counter must not advance past it.
  assign addr_at_max = (addr_q == {NB_ADDR{1'b1}});

  // State register and all registered outputs; reset parks the CPU in reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= LD_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      low_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      low_q       <= low_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state and next-output logic; i_start overrides everything,
  // including a coincident byte strobe, which is then dropped.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    low_d       = low_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    overflow_d  = overflow_q;

    if (i_start) begin
      state_d     = LD_LOAD_LOW;
      addr_d      = '0;
      count_d     = '0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      cpu_reset_d = 1'b1;
    end else begin
      case (state_q)
        LD_IDLE: begin
          // Bytes arriving before a start pulse are not program data.
        end

        LD_LOAD_LOW: begin
          if (i_rx_valid) begin
            low_d   = i_rx_data;
            state_d = LD_LOAD_HIGH;
          end
        end

        LD_LOAD_HIGH: begin
          if (i_rx_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = rx_word;
            count_d   = count_q + 1'b1;
            // Saturate so a full memory never wraps back onto address 0.
            if (!addr_at_max) begin
              addr_d = addr_q + 1'b1;
            end
            if (rx_is_halt) begin
              // Released together with the HALT write: memory captures the
              // last word at the end of this cycle, before the first fetch.
              state_d     = LD_DONE;
              cpu_reset_d = 1'b0;
              done_d      = 1'b1;
            end else if (addr_at_max) begin
              state_d    = LD_ERROR;
              overflow_d = 1'b1;
            end else begin
              state_d = LD_LOAD_LOW;
            end
          end
        end

        LD_DONE, LD_ERROR: begin
          // Terminal until the next start pulse; further bytes are ignored.
        end

        default: begin
          state_d = LD_IDLE;
        end
      endcase
    end
  end

  assign o_mem_wr_enable = wr_en_q;
  assign o_mem_wr_addr   = wr_addr_q;
  assign o_mem_wr_data   = wr_data_q;
  assign o_cpu_reset     = cpu_reset_q;
  assign o_load_done     = done_q;
  assign o_overflow      = overflow_q;
  assign o_word_count    = count_q;

endmodule : bip_program_loader
`default_nettype wire

// File: tb/tb_bip_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bip_program_loader
//  Purpose  : Scoreboard bench for bip_program_loader with a 3-bit address
//             space so the overflow boundary is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bip_program_loader;

  localparam int NB_ADDR = 3;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        start    = 1'b0;

  logic               mem_wr_enable;
  logic [NB_ADDR-1:0] mem_wr_addr;
  logic [15:0]        mem_wr_data;
  logic               cpu_reset;
  logic               load_done;
  logic               overflow;
  logic [NB_ADDR:0]   word_count;

  bip_program_loader #(
    .NB_INSTRUCTION (16),
    .NB_ADDR        (NB_ADDR),
    .NB_OPCODE      (5),
    .NB_BYTE        (8)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_start         (start),
    .o_mem_wr_enable (mem_wr_enable),
    .o_mem_wr_addr   (mem_wr_addr),
    .o_mem_wr_data   (mem_wr_data),
    .o_cpu_reset     (cpu_reset),
    .o_load_done     (load_done),
    .o_overflow      (overflow),
    .o_word_count    (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB_ADDR-1:0] addr;
    logic [15:0]        data;
    int                 cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    if (mem_wr_enable) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none (t=%0t)",
                 mem_wr_addr, mem_wr_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr",  32'(mem_wr_addr), 32'(e.addr));
        check("wr_data",  32'(mem_wr_data), 32'(e.data));
        check("wr_cycle", 32'(cyc),         32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends one word low byte first; when a write is expected it is due in the
  // cycle after the high-byte strobe is captured.
  task automatic send_word(input logic [15:0] w, input bit exp_write,
                           input logic [NB_ADDR-1:0] exp_addr);
    wr_t e;
    send_byte(w[7:0]);
    if (exp_write) begin
      e.addr = exp_addr;
      e.data = w;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    send_byte(w[15:8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low: bytes are ignored and outputs are at reset values.
    tick(2);
    send_byte(8'h55);
    send_byte(8'h66);
    check("rst_cpu_reset", 32'(cpu_reset),     32'd1);
    check("rst_wr_en",     32'(mem_wr_enable), 32'd0);
    check("rst_wr_addr",   32'(mem_wr_addr),   32'd0);
    check("rst_wr_data",   32'(mem_wr_data),   32'd0);
    check("rst_done",      32'(load_done),     32'd0);
    check("rst_overflow",  32'(overflow),      32'd0);
    check("rst_count",     32'(word_count),    32'd0);
    rst_n = 1'b1;
    // Bytes in IDLE must not produce writes.
    send_byte(8'h11);
    send_byte(8'h22);
    tick(2);
    check("idle_count",     32'(word_count), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset),  32'd1);

    // Basic two-word load ending in HALT.
    pulse_start();
    send_word(16'h0805, 1'b1, 3'd0);
    send_word(16'h0000, 1'b1, 3'd1);
    check("halt_cycle_wr_en",     32'(mem_wr_enable), 32'd1);
    check("halt_cycle_done",      32'(load_done),     32'd1);
    check("halt_cycle_cpu_reset", 32'(cpu_reset),     32'd0);
    tick(1);
    check("basic_count", 32'(word_count), 32'd2);
    send_word(16'h1234, 1'b0, 3'd0);
    tick(1);
    check("done_ignores_count", 32'(word_count), 32'd2);
    check("done_still_done",    32'(load_done),  32'd1);

    // Back-to-back strobes across three words.
    pulse_start();
    send_word(16'h1001, 1'b1, 3'd0);
    send_word(16'h2002, 1'b1, 3'd1);
    send_word(16'h0000, 1'b1, 3'd2);
    tick(1);
    check("b2b_done",      32'(load_done),  32'd1);
    check("b2b_count",     32'(word_count), 32'd3);
    check("b2b_cpu_reset", 32'(cpu_reset),  32'd0);

    // Restart from DONE.
    pulse_start();
    check("restart_cpu_reset", 32'(cpu_reset),  32'd1);
    check("restart_done",      32'(load_done),  32'd0);
    check("restart_count",     32'(word_count), 32'd0);
    send_word(16'h1234, 1'b1, 3'd0);
    send_word(16'h2345, 1'b1, 3'd1);

    // Reset after the low byte of word 2.
    send_byte(8'h45);
    rst_n = 1'b0;
    #1;
    check("midrst_count",     32'(word_count),    32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset),     32'd1);
    check("midrst_wr_en",     32'(mem_wr_enable), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h23);
    tick(1);
    check("midrst_idle_count", 32'(word_count), 32'd0);
    pulse_start();
    send_word(16'h3456, 1'b1, 3'd0);
    send_word(16'h0000, 1'b1, 3'd1);
    tick(1);
    check("reload_done",  32'(load_done),  32'd1);
    check("reload_count", 32'(word_count), 32'd2);

    // Start coincident with a byte strobe: the byte is dropped.
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    send_word(16'h1234, 1'b1, 3'd0);
    send_word(16'h0000, 1'b1, 3'd1);
    tick(1);
    check("coinc_count", 32'(word_count), 32'd2);
    check("coinc_done",  32'(load_done),  32'd1);

    // Fill the 8-entry memory without HALT.
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send_word(16'h0801 + 16'(i << 8), 1'b1, 3'(i));
    end
    tick(1);
    check("pre_ovf_overflow", 32'(overflow),   32'd0);
    check("pre_ovf_count",    32'(word_count), 32'd7);
    send_word(16'h0F01, 1'b1, 3'd7);
    tick(1);
    check("ovf_overflow",  32'(overflow),   32'd1);
    check("ovf_cpu_reset", 32'(cpu_reset),  32'd1);
    check("ovf_count",     32'(word_count), 32'd8);
    check("ovf_done",      32'(load_done),  32'd0);
    send_word(16'h0000, 1'b0, 3'd0);
    send_word(16'h0801, 1'b0, 3'd0);
    tick(2);
    check("ovf_ignore_count",    32'(word_count), 32'd8);
    check("ovf_ignore_overflow", 32'(overflow),   32'd1);

    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bip_program_loader
`default_nettype wire
